// File: rtl/stream_packer.sv
// stream_packer: narrow-to-wide stream up-converter with a registered valid/ready output.
// Define STREAM_PACKER_KEEP_EN to add in_last/out_last/out_keep for early-closed words.
module stream_packer #(
  parameter  int unsigned IN_W  = 8,
  parameter  int unsigned RATIO = 4,
  localparam int unsigned OUT_W = IN_W * RATIO,
  localparam int unsigned CNT_W = $clog2(RATIO)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
`ifdef STREAM_PACKER_KEEP_EN
  input  logic             in_last,
  output logic             out_last,
  output logic [RATIO-1:0] out_keep,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] merged;
  logic             in_hs, out_hs, close;
`ifdef STREAM_PACKER_KEEP_EN
  logic             last_q, last_d;
  logic [RATIO-1:0] keep_q, keep_d, keep_w;
`endif

  assign in_ready = !valid_q || out_ready;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = valid_q && out_ready;
`ifdef STREAM_PACKER_KEEP_EN
  assign close    = (cnt_q == CNT_W'(RATIO - 1)) || in_last;
`else
  assign close    = (cnt_q == CNT_W'(RATIO - 1));
`endif

  // Accumulator with the incoming beat placed at lane cnt and every higher lane zeroed;
  // serves both as the next accumulator and as the completed word.
  always_comb begin
    merged = '0;
`ifdef STREAM_PACKER_KEEP_EN
    keep_w = '0;
`endif
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (CNT_W'(i) < cnt_q) begin
        merged[i*IN_W +: IN_W] = acc_q[i*IN_W +: IN_W];
      end else if (CNT_W'(i) == cnt_q) begin
        merged[i*IN_W +: IN_W] = in_data;
      end
`ifdef STREAM_PACKER_KEEP_EN
      keep_w[i] = (CNT_W'(i) <= cnt_q);
`endif
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
`ifdef STREAM_PACKER_KEEP_EN
    last_d  = last_q;
    keep_d  = keep_q;
`endif
    if (out_hs) begin
      valid_d = 1'b0;
    end
    // A completing beat overrides the drain above so a new word loads without a bubble.
    if (in_hs) begin
      if (close) begin
        data_d  = merged;
        valid_d = 1'b1;
        cnt_d   = '0;
        acc_d   = '0;
`ifdef STREAM_PACKER_KEEP_EN
        keep_d  = keep_w;
        last_d  = in_last;
`endif
      end else begin
        acc_d = merged;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef STREAM_PACKER_KEEP_EN
      last_q  <= 1'b0;
      keep_q  <= '0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
`ifdef STREAM_PACKER_KEEP_EN
      last_q  <= last_d;
      keep_q  <= keep_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
`ifdef STREAM_PACKER_KEEP_EN
  assign out_last  = last_q;
  assign out_keep  = keep_q;
`endif

endmodule

// File: doc/stream_packer.md
# stream_packer

Width up-converter that sits directly downstream of the FIFO's valid/ready read side. It consumes a narrow stream of IN_W-bit beats and emits IN_W*RATIO-bit words on a registered valid/ready output. It absorbs FIFO back-pressure and sustains one input beat per cycle while the output drains.

## Interface
- IN_W, default 8: input beat width in bits.
- RATIO, default 4: input beats per output word; power of two, at least 2.
- OUT_W, localparam, = IN_W*RATIO: output word width.
- CNT_W, localparam, = $clog2(RATIO): lane counter width.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat present; connects to the FIFO's "not empty".
- in_ready  out  1  packer accepts the beat; connects to the FIFO's read request.
- in_data  in  IN_W  input beat; sampled only on an input handshake.
- in_last  in  1  closes the current word early; present only with STREAM_PACKER_KEEP_EN.
- out_valid  out  1  out_data holds a complete word.
- out_ready  in  1  downstream accepts the word.
- out_data  out  OUT_W  packed word; the first beat occupies lane 0 (bits [IN_W-1:0]).
- out_last  out  1  word was closed by in_last; present only with STREAM_PACKER_KEEP_EN.
- out_keep  out  RATIO  lane-valid mask; present only with STREAM_PACKER_KEEP_EN.

## Operation
- State:
  - lane counter cnt (CNT_W bits)
  - accumulator acc (OUT_W bits)
  - output register: out_data, out_valid, plus out_last and out_keep when compiled in.
- Handshakes:
  - Input handshake: in_valid && in_ready.
  - Output handshake: out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is combinational and conservative: it is deasserted whenever a word is stalled, even if the incoming beat would not complete a word.
- Non-completing input handshake (cnt != RATIO-1 and no in_last):
  - acc[cnt*IN_W +: IN_W] <= in_data
  - cnt <= cnt+1
- Completing input handshake (cnt == RATIO-1, or in_last when compiled in):
  - out_data <= acc with in_data merged into lane cnt.
  - Lanes above cnt are forced to 0.
  - out_valid <= 1.
  - cnt <= 0 and acc <= 0.
- Output handshake with no completing input handshake in the same cycle: out_valid <= 0. out_data holds its value.
- Output handshake and completing input handshake in the same cycle: the new word loads and out_valid stays 1. No bubble.
- Counter wrap: cnt wraps from RATIO-1 to 0 only via the completing path, never by overflow.
- in_data is never sampled without a handshake, so the FIFO's zeroed r_data when idle is harmless.

## Timing
- Reset values: all of the following are 0.
  - out_valid, out_data
  - out_last, out_keep (when compiled in)
  - cnt, acc
- in_ready is therefore 1 once reset is released.
- Latency: out_valid rises on the edge that captures the completing beat, so the word is visible the cycle after that beat's handshake.
- Throughput:
  - One input beat per cycle sustained while out_ready=1.
  - One output word per RATIO cycles.
  - A word completed by in_last can follow the previous word back to back.
- Stall: while out_valid && !out_ready, all of these hold stable and in_ready=0:
  - out_data
  - out_last, out_keep (when compiled in)
- Reset mid-word: partial acc and cnt are discarded, and any pending output word is dropped.
- Combinational paths: out_valid/out_ready to in_ready only. There is no path from in_valid to out_valid.

## Configuration
- Macro STREAM_PACKER_KEEP_EN.
- Defined:
  - Ports in_last, out_last and out_keep exist.
  - A beat with in_last completes the word at lane cnt, giving out_keep = (1 << (cnt+1)) - 1 and out_last = 1.
  - A full word completed without in_last gives out_keep = all ones and out_last = 0.
  - A beat at cnt == RATIO-1 that also has in_last gives out_keep = all ones and out_last = 1.
- Undefined:
  - Ports in_last, out_last and out_keep are absent.
  - A word completes only after RATIO beats.

## Test plan
- Back-to-back full rate, defaults: beats 0x11,0x22,0x33,0x44,0x55..0x88 with out_ready=1 -> out_data 0x44332211, then 0x88776655 exactly 4 cycles later; in_ready stays 1.
- Output stall: complete 0xDDCCBBAA, hold out_ready=0 for 5 cycles -> out_data stable, in_ready=0, no beat consumed; releasing out_ready produces one output handshake and in_ready=1 the same cycle.
- Simultaneous events: out_ready=1 while the 4th beat of the next word handshakes -> out_valid stays 1 and out_data changes on that edge with no idle cycle.
- STREAM_PACKER_KEEP_EN: beats 0xA1,0xA2 with in_last on 0xA2 -> out_data 0x0000A2A1, out_keep 4'b0011, out_last 1; the next word starts at lane 0.
- Reset mid-word: 2 beats, assert reset_n=0 for 1 cycle, then 4 beats 0x01..0x04 -> single word 0x04030201, and all outputs are 0 during reset.
- FIFO integration: fifo ROWS=8 feeding the packer, write 16 bytes while out_ready toggles randomly -> 4 words in order with no loss or duplication.
